// File: rtl/bus_arbiter_rr_if.sv
// Shared-bus port bundle between the round-robin arbiter (master) and the bus target (slave).
interface bus_arbiter_rr_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_we;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_addr, bus_wdata, bus_we,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_addr, bus_wdata, bus_we,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter that forwards one requester transfer at a time onto the shared bus,
// holds the grant until completion or timeout, and returns a one-cycle ack with read data.
module bus_arbiter_rr #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*ADDR_W-1:0] addr_i,
    input  logic [N_REQ*DATA_W-1:0] wdata_i,
    input  logic [N_REQ-1:0]        we_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic [N_REQ-1:0]        ack_o,
    output logic                    err_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    busy_o,
    bus_arbiter_rr_if.master        bus_if
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [N_REQ-1:0]  grant_q,    grant_d;
    logic [N_REQ-1:0]  ack_q,      ack_d;
    logic              err_q,      err_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;
    logic              busy_q,     busy_d;
    logic              valid_q,    valid_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              we_q,       we_d;
    logic [PTR_W-1:0]  last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic [PTR_W:0]    pick_s;
    logic              win_found_s;
    logic [PTR_W-1:0]  win_idx_s;

    // First set request strictly after 'last', wrapping modulo N_REQ; MSB flags a hit.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [PTR_W-1:0] last);
        logic [PTR_W:0]   res;
        logic [PTR_W-1:0] cand_idx;
        int               cand;
        res = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(last) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end else begin
                cand = cand;
            end
            cand_idx = cand[PTR_W-1:0];
            if (!res[PTR_W] && req[cand_idx]) begin
                res = {1'b1, cand_idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s      = rr_pick(req_i, last_ptr_q);
    assign win_found_s = pick_s[PTR_W];
    assign win_idx_s   = pick_s[PTR_W-1:0];

    // Next-state logic for the IDLE/XFER/RESP transfer sequencer.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ack_d      = '0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        last_ptr_d = last_ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found_s) begin
                    grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                    last_ptr_d = win_idx_s;
                    addr_d     = addr_i[win_idx_s*ADDR_W +: ADDR_W];
                    wdata_d    = wdata_i[win_idx_s*DATA_W +: DATA_W];
                    we_d       = we_i[win_idx_s];
                    valid_d    = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_XFER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (bus_if.bus_ready) begin
                    if (!we_q) begin
                        rdata_d = bus_if.bus_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    err_d   = 1'b0;
                    valid_d = 1'b0;
                    ack_d   = grant_q;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    ack_d   = grant_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                grant_d = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                err_d   = 1'b0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            last_ptr_q <= PTR_W'(N_REQ - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            last_ptr_q <= last_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant_o          = grant_q;
    assign ack_o            = ack_q;
    assign err_o            = err_q;
    assign rdata_o          = rdata_q;
    assign busy_o           = busy_q;
    assign bus_if.bus_valid = valid_q;
    assign bus_if.bus_addr  = addr_q;
    assign bus_if.bus_wdata = wdata_q;
    assign bus_if.bus_we    = we_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: ack/err/rdata expectations go through a scoreboard queue.
module tb_bus_arbiter_rr;
    localparam int N = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        logic [N-1:0]  ack;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_v = '0;
    logic [N*AW-1:0] addr_v = '0;
    logic [N*DW-1:0] wdata_v = '0;
    logic [N-1:0]    we_v = '0;
    logic [N-1:0]    grant_o, ack_o;
    logic            err_o, busy_o;
    logic [DW-1:0]   rdata_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t exp_q[$];
    logic [DW-1:0] exp_rdata = '0;
    int g_prev, g_now;

    bus_arbiter_rr_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    bus_arbiter_rr #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req_v), .addr_i(addr_v), .wdata_i(wdata_v),
        .we_i(we_v), .grant_o(grant_o), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
        .busy_o(busy_o), .bus_if(bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ack pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (ack_o !== '0) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ack", 64'(ack_o), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_ack", 64'(ack_o), 64'(e.ack));
                chk("sb_err", 64'(err_o), 64'(e.err));
                chk("sb_rdata", 64'(rdata_o), 64'(e.rdata));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 64'(grant_o), 64'd0);
        chk({tag, "_ack"}, 64'(ack_o), 64'd0);
        chk({tag, "_err"}, 64'(err_o), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata_o), 64'd0);
        chk({tag, "_valid"}, 64'(bif.bus_valid), 64'd0);
        chk({tag, "_addr"}, 64'(bif.bus_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(bif.bus_wdata), 64'd0);
        chk({tag, "_we"}, 64'(bif.bus_we), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    // Wait for a grant to requester idx, answer after 'delay' XFER cycles, check the ack edge.
    task automatic xfer(input string tag, input int idx, input int delay,
                        input logic [DW-1:0] rd, input int drop_at, output int gcyc);
        int n;
        exp_t e;
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        n = 0;
        gcyc = -1;
        while (bif.bus_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (bif.bus_valid !== 1'b1) begin
            chk({tag, "_wait_grant"}, 64'd0, 64'd1);
            return;
        end
        gcyc = cyc;
        chk({tag, "_grant"}, 64'(grant_o), 64'(oh));
        chk({tag, "_addr"}, 64'(bif.bus_addr), 64'(addr_v[idx*AW +: AW]));
        chk({tag, "_we"}, 64'(bif.bus_we), 64'(we_v[idx]));
        if (!we_v[idx]) exp_rdata = rd;
        e.ack = oh;
        e.err = 1'b0;
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        for (int d = 0; d < delay; d++) begin
            step();
            if (d == drop_at) req_v[idx] = 1'b0;
        end
        bif.bus_ready = 1'b1;
        bif.bus_rdata = rd;
        step();
        bif.bus_ready = 1'b0;
        bif.bus_rdata = '0;
        chk({tag, "_ack_edge"}, 64'(ack_o), 64'(oh));
        chk({tag, "_valid_drop"}, 64'(bif.bus_valid), 64'd0);
        chk({tag, "_busy_resp"}, 64'(busy_o), 64'd1);
    endtask

    initial begin
        int n;
        exp_t e;
        bif.bus_ready = 1'b0;
        bif.bus_rdata = '0;
        for (int i = 0; i < N; i++) begin
            addr_v[i*AW +: AW] = 32'h100 + 32'(i) * 32'd4;
            wdata_v[i*DW +: DW] = 32'h5500_0000 + 32'(i);
        end
        repeat (3) step();
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Single read from requester 0, ready two cycles after bus_valid.
        addr_v[0 +: AW] = 32'h10;
        req_v = 4'b0001;
        xfer("read1", 0, 2, 32'hCAFE_0001, -1, g_now);
        req_v = '0;
        step();
        chk("read1_idle_busy", 64'(busy_o), 64'd0);
        chk("read1_rdata_hold", 64'(rdata_o), 64'h0000_0000_CAFE_0001);

        // Reset in the middle of a transfer: everything clears, no ack.
        addr_v[0 +: AW] = 32'h100;
        req_v = 4'b0001;
        step();
        step();
        chk("rst_mid_valid_before", 64'(bif.bus_valid), 64'd1);
        reset_n = 1'b0;
        step();
        chk_all_zero("rst_mid");
        reset_n = 1'b1;
        req_v = 4'b1111;

        // Fairness: all requesting, instant ready -> 0,1,2,3,0 every 3 cycles.
        g_prev = -1;
        for (int k = 0; k < 5; k++) begin
            xfer($sformatf("rr%0d", k), k % N, 0, 32'hA000_0000 + 32'(k), -1, g_now);
            if (k > 0) chk($sformatf("rr%0d_spacing", k), 64'(g_now - g_prev), 64'd3);
            g_prev = g_now;
        end
        req_v = '0;
        step();

        // Rotation: last grant 2, then 0011 -> 0, then 1001 -> 3.
        req_v = 4'b0100;
        xfer("rot_a", 2, 0, 32'hB000_0002, -1, g_now);
        req_v = 4'b0011;
        xfer("rot_b", 0, 1, 32'hB000_0000, -1, g_now);
        req_v = 4'b1001;
        xfer("rot_c", 3, 0, 32'hB000_0003, -1, g_now);
        req_v = '0;
        step();

        // Requester 2 drops req in its second XFER cycle; ack still issued.
        req_v = 4'b0100;
        xfer("drop", 2, 3, 32'hD00D_0002, 0, g_now);
        chk("drop_req_low", 64'(req_v), 64'd0);
        step();

        // Timeout: write from requester 1, no ready -> 8 valid cycles then ack+err.
        we_v = 4'b0010;
        addr_v[1*AW +: AW] = 32'h200;
        wdata_v[1*DW +: DW] = 32'hDEAD_BEEF;
        req_v = 4'b0010;
        n = 0;
        while (bif.bus_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("to_grant", 64'(grant_o), 64'b0010);
        chk("to_we", 64'(bif.bus_we), 64'd1);
        chk("to_wdata", 64'(bif.bus_wdata), 64'h0000_0000_DEAD_BEEF);
        e.ack = 4'b0010;
        e.err = 1'b1;
        e.rdata = exp_rdata;
        exp_q.push_back(e);
        n = 0;
        while (bif.bus_valid === 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("to_valid_cycles", 64'(n), 64'd8);
        chk("to_ack", 64'(ack_o), 64'b0010);
        chk("to_err", 64'(err_o), 64'd1);
        req_v = '0;
        we_v = '0;
        step();
        chk("to_idle_busy", 64'(busy_o), 64'd0);
        chk("to_idle_ack", 64'(ack_o), 64'd0);
        chk("to_idle_err", 64'(err_o), 64'd0);
        chk("to_idle_grant", 64'(grant_o), 64'd0);

        repeat (3) step();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
